// File: rtl/ddr_port_arbiter.sv
// Purpose: round-robin arbiter sharing one DDR controller among four burst ports.
// Latency: arbitration to cmd_valid/gnt is 1 clk; ctrl_rd_valid to rd_valid is 1 clk.
// Backpressure: a port's req is held until gnt; no arbitration unless IDLE and ctrl_ready.
// Ports: req/req_we/req_addr/req_wdata in from the ports, gnt/rd_valid/rd_data back to them;
//        cmd_valid/cmd/cmd_addr/cmd_wdata to the controller, ctrl_ready/ctrl_rd_*/ctrl_wr_done from it;
//        busy while a transaction is outstanding, err is the sticky watchdog flag.
// Optional: define ARB_TIMEOUT_EN to enable the TIMEOUT-cycle completion watchdog.
module ddr_port_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int ROW_LSB = 10,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [3:0]            req_we,
    input  logic [4*ADDR_W-1:0]   req_addr,
    input  logic [4*128-1:0]      req_wdata,
    output logic [3:0]            gnt,
    output logic [3:0]            rd_valid,
    output logic [127:0]          rd_data,
    output logic                  busy,
    output logic                  err,
    input  logic                  ctrl_ready,
    output logic                  cmd_valid,
    output logic [3:0]            cmd,
    output logic [ADDR_W-1:0]     cmd_addr,
    output logic [127:0]          cmd_wdata,
    input  logic                  ctrl_rd_valid,
    input  logic [127:0]          ctrl_rd_data,
    input  logic                  ctrl_wr_done
);

    localparam logic [3:0] CMD_RD     = 4'b0001;
    localparam logic [3:0] CMD_RD_PRE = 4'b0011;
    localparam logic [3:0] CMD_WR     = 4'b0010;
    localparam logic [3:0] CMD_WR_PRE = 4'b0100;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR} state_t;

    state_t              state_q, state_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;
    logic [1:0]          owner_q, owner_d;
    logic                owner_we_q, owner_we_d;
    logic [3:0]          gnt_q, gnt_d;
    logic [3:0]          rd_valid_q, rd_valid_d;
    logic [127:0]        rd_data_q, rd_data_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [3:0]          cmd_q, cmd_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [127:0]        cmd_wdata_q, cmd_wdata_d;

    logic [ADDR_W-1:0]   addr_a  [4];
    logic [127:0]        wdata_a [4];
    logic                win_vld;
    logic [1:0]          win_idx;
    logic                row_hit;

    for (genvar p = 0; p < 4; p++) begin : g_unpack
        assign addr_a[p]  = req_addr[p*ADDR_W +: ADDR_W];
        assign wdata_a[p] = req_wdata[p*128 +: 128];
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        win_vld = 1'b0;
        win_idx = rr_ptr_q;
        for (int i = 1; i <= 4; i++) begin
            if (!win_vld && req[rr_ptr_q + 2'(i)]) begin
                win_vld = 1'b1;
                win_idx = rr_ptr_q + 2'(i);
            end
        end
    end

    // Keep the row open when another pending port targets the same bank+row.
    always_comb begin
        row_hit = 1'b0;
        for (int p = 0; p < 4; p++) begin
            if (2'(p) != win_idx && req[p] &&
                addr_a[p][ADDR_W-1:ROW_LSB] == addr_a[win_idx][ADDR_W-1:ROW_LSB])
                row_hit = 1'b1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             tmo_hit;
    // Fires on the TIMEOUT-th cycle spent waiting; err is visible the cycle after.
    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign err     = err_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign err            = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        owner_we_d  = owner_we_q;
        gnt_d       = 4'b0000;
        rd_valid_d  = 4'b0000;
        rd_data_d   = rd_data_q;
        cmd_valid_d = 1'b0;
        cmd_d       = cmd_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld && ctrl_ready) begin
                    owner_d     = win_idx;
                    owner_we_d  = req_we[win_idx];
                    rr_ptr_d    = win_idx;
                    cmd_addr_d  = addr_a[win_idx];
                    cmd_wdata_d = wdata_a[win_idx];
                    if (req_we[win_idx]) cmd_d = row_hit ? CMD_WR : CMD_WR_PRE;
                    else                 cmd_d = row_hit ? CMD_RD : CMD_RD_PRE;
                    cmd_valid_d = 1'b1;
                    gnt_d       = 4'b0001 << win_idx;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = owner_we_q ? WAIT_WR : WAIT_RD;
`ifdef ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT_RD: begin
`ifdef ARB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (ctrl_rd_valid) begin
                    rd_data_d  = ctrl_rd_data;
                    rd_valid_d = 4'b0001 << owner_q;
                    state_d    = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            WAIT_WR: begin
`ifdef ARB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (ctrl_wr_done) begin
                    state_d = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 2'd3;
            owner_q     <= 2'd0;
            owner_we_q  <= 1'b0;
            gnt_q       <= 4'b0000;
            rd_valid_q  <= 4'b0000;
            rd_data_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= 4'b0000;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            owner_we_q  <= owner_we_d;
            gnt_q       <= gnt_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign busy      = (state_q != IDLE);
    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_wdata = cmd_wdata_q;

endmodule
